// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of the shared adder: per-requester request, lock,
// carry-in and operands going in; grant and tagged result coming back.
interface adder_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    cin;
    logic [16*NREQ-1:0] a_flat;
    logic [16*NREQ-1:0] b_flat;
    logic [NREQ-1:0]    gnt;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [15:0]        res_sum;
    logic               res_cout;
    logic               res_last;

    // Requesters drive operands and watch grant/result.
    modport master (
        output req, lock, cin, a_flat, b_flat,
        input  gnt, res_valid, res_id, res_sum, res_cout, res_last
    );

    // The arbitrated adder consumes operands and returns results.
    modport slave (
        input  req, lock, cin, a_flat, b_flat,
        output gnt, res_valid, res_id, res_sum, res_cout, res_last
    );
endinterface

// File: rtl/adder_arbiter.sv
// One 16-bit carry-select adder shared by NREQ requesters. Round-robin
// arbitration picks one beat per cycle; a lock keeps the adder for the same
// requester on following beats and feeds the previous carry-out back in, so
// wide adds can be built from 16-bit words. Results appear one cycle later.
module adder_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    adder_arbiter_if.slave bus
);
    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [IDW-1:0] own_id_reg, own_id_next;
    logic [3:0]     lock_cnt_reg, lock_cnt_next;
    logic           carry_reg;

    logic           res_valid_reg;
    logic [IDW-1:0] res_id_reg;
    logic [15:0]    res_sum_reg;
    logic           res_cout_reg;
    logic           res_last_reg;

    logic [NREQ-1:0] gnt_comb;
    logic [IDW-1:0]  gnt_idx;
    logic            beat;
    logic [15:0]     a_sel, b_sel;
    logic            cin_sel, lock_sel, lock_take;
    logic [15:0]     add_sum;
    logic [4:0]      carry_chain;

    // Grant: owner only while locked, otherwise first request from rr_ptr upward.
    always_comb begin
        int idx;
        idx      = 0;
        gnt_comb = '0;
        gnt_idx  = '0;
        beat     = 1'b0;
        if (state_reg == ST_LOCKED) begin
            gnt_idx = own_id_reg;
            if (bus.req[own_id_reg]) begin
                beat                 = 1'b1;
                gnt_comb[own_id_reg] = 1'b1;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!beat && bus.req[idx]) begin
                    beat          = 1'b1;
                    gnt_idx       = IDW'(idx);
                    gnt_comb[idx] = 1'b1;
                end
            end
        end
    end

    // Operand steering; locked beats take their carry from the previous beat.
    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        cin_sel  = 1'b0;
        lock_sel = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_sel    = bus.a_flat[16*i +: 16];
                b_sel    = bus.b_flat[16*i +: 16];
                cin_sel  = bus.cin[i];
                lock_sel = bus.lock[i];
            end
        end
        if (state_reg == ST_LOCKED) cin_sel = carry_reg;
    end

    // Carry-select adder: each 4-bit block precomputes both carry cases and
    // the incoming block carry picks one.
    assign carry_chain[0] = cin_sel;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_csel
            logic [4:0] sum_c0, sum_c1;
            assign sum_c0 = {1'b0, a_sel[4*gi +: 4]} + {1'b0, b_sel[4*gi +: 4]};
            assign sum_c1 = {1'b0, a_sel[4*gi +: 4]} + {1'b0, b_sel[4*gi +: 4]} + 5'd1;
            assign add_sum[4*gi +: 4] = carry_chain[gi] ? sum_c1[3:0] : sum_c0[3:0];
            assign carry_chain[gi+1]  = carry_chain[gi] ? sum_c1[4]   : sum_c0[4];
        end
    endgenerate

    // A lock is honoured only on a real beat and while the beat budget remains.
    assign lock_take = beat && lock_sel &&
                       (({1'b0, lock_cnt_reg} + 5'd1) < 5'(MAX_LOCK));

    // Next-state: lock entry/continuation, release, and round-robin advance.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        own_id_next   = own_id_reg;
        lock_cnt_next = lock_cnt_reg;
        if (beat) begin
            if (lock_take) begin
                state_next    = ST_LOCKED;
                own_id_next   = gnt_idx;
                lock_cnt_next = lock_cnt_reg + 4'd1;
            end else begin
                state_next    = ST_ARB;
                lock_cnt_next = 4'd0;
                rr_ptr_next   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            end
        end else if (state_reg == ST_LOCKED) begin
            // Owner dropped its request: abandon the chain, pointer stays put.
            state_next    = ST_ARB;
            lock_cnt_next = 4'd0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_ARB;
            rr_ptr_reg   <= '0;
            own_id_reg   <= '0;
            lock_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            own_id_reg   <= own_id_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // Result register and chained carry, updated only on granted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            res_sum_reg   <= '0;
            res_cout_reg  <= 1'b0;
            res_last_reg  <= 1'b0;
            carry_reg     <= 1'b0;
        end else begin
            res_valid_reg <= beat;
            if (beat) begin
                res_id_reg   <= gnt_idx;
                res_sum_reg  <= add_sum;
                res_cout_reg <= carry_chain[4];
                res_last_reg <= !lock_take;
                carry_reg    <= carry_chain[4];
            end
        end
    end

    assign bus.gnt       = gnt_comb & {NREQ{rst_n}};
    assign bus.res_valid = res_valid_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_sum   = res_sum_reg;
    assign bus.res_cout  = res_cout_reg;
    assign bus.res_last  = res_last_reg;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: the driver checks grants and queues the
// expected results; a monitor pops and compares whenever res_valid is seen.
module tb_adder_arbiter;
    logic clk;
    logic rst_n;

    adder_arbiter_if #(.NREQ(4), .IDW(2)) bus();

    adder_arbiter #(.NREQ(4), .IDW(2), .MAX_LOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Monitor: every presented result must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t got, exp;
        if (rst_n && bus.res_valid) begin
            got = '{bus.res_id, bus.res_sum, bus.res_cout, bus.res_last};
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got id=%0d sum=%h cout=%b last=%b, required no result",
                         got.id, got.sum, got.cout, got.last);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL result got id=%0d sum=%h cout=%b last=%b, required id=%0d sum=%h cout=%b last=%b",
                             got.id, got.sum, got.cout, got.last, exp.id, exp.sum, exp.cout, exp.last);
                end else begin
                    $display("result id=%0d sum=%h cout=%b last=%b ok", got.id, got.sum, got.cout, got.last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] c);
        bus.req  = r;
        bus.lock = l;
        bus.cin  = c;
    endtask

    task automatic ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.a_flat[16*i +: 16] = a;
        bus.b_flat[16*i +: 16] = b;
    endtask

    // Called at posedge+1: check the grant, queue the expected result, advance.
    task automatic step(input string name, input logic [3:0] exp_gnt, input bit push,
                        input logic [1:0] id, input logic [15:0] sum,
                        input logic cout, input logic last);
        #3;
        checks++;
        if (bus.gnt !== exp_gnt) begin
            failures++;
            $display("FAIL %s gnt got=%b required=%b", name, bus.gnt, exp_gnt);
        end else begin
            $display("beat %s req=%b lock=%b gnt=%b", name, bus.req, bus.lock, bus.gnt);
        end
        if (push) sb_q.push_back('{id, sum, cout, last});
        @(posedge clk);
        #1;
    endtask

    logic [15:0] rr_sum [4];
    logic [3:0]  one_hot;

    initial begin
        rr_sum[0] = 16'h1112;
        rr_sum[1] = 16'h2225;
        rr_sum[2] = 16'h3336;
        rr_sum[3] = 16'h4449;

        rst_n      = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000);
        bus.a_flat = '0;
        bus.b_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_valid", 32'(bus.res_valid), 32'h0);
        chk("reset_id", 32'(bus.res_id), 32'h0);
        chk("reset_sum", 32'(bus.res_sum), 32'h0);
        chk("reset_cout", 32'(bus.res_cout), 32'h0);
        chk("reset_last", 32'(bus.res_last), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle, then single request.
        step("idle", 4'b0000, 0, 2'd0, 16'h0, 1'b0, 1'b0);
        ops(0, 16'h1234, 16'h0FF0);
        drive(4'b0001, 4'b0000, 4'b0000);
        step("single", 4'b0001, 1, 2'd0, 16'h2224, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 4'b0000);
        step("idle2", 4'b0000, 0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Round robin from rr_ptr=1 with all four requesting.
        ops(0, 16'h1111, 16'h0001);
        ops(1, 16'h2222, 16'h0002);
        ops(2, 16'h3333, 16'h0003);
        ops(3, 16'h4444, 16'h0004);
        drive(4'b1111, 4'b0000, 4'b1010);
        for (int k = 0; k < 8; k++) begin
            int id;
            id      = (k + 1) % 4;
            one_hot = 4'b0001 << id;
            step("round_robin", one_hot, 1, 2'(id), rr_sum[id], 1'b0, 1'b1);
        end

        // Chained 32-bit add on requester 2 while requester 1 also requests.
        drive(4'b0110, 4'b0000, 4'b0000);
        step("chain_pre", 4'b0010, 1, 2'd1, 16'h2224, 1'b0, 1'b1);
        ops(2, 16'hFFFF, 16'h0001);
        drive(4'b0110, 4'b0100, 4'b0000);
        step("chain_b1", 4'b0100, 1, 2'd2, 16'h0000, 1'b1, 1'b0);
        ops(2, 16'h0000, 16'h0000);
        drive(4'b0110, 4'b0000, 4'b0100);
        step("chain_b2", 4'b0100, 1, 2'd2, 16'h0001, 1'b0, 1'b1);
        drive(4'b0110, 4'b0000, 4'b0000);
        step("chain_post", 4'b0010, 1, 2'd1, 16'h2224, 1'b0, 1'b1);

        // Lock timeout: four beats to requester 0, carry chained, then requester 1.
        ops(0, 16'h8000, 16'h8000);
        drive(4'b0011, 4'b0001, 4'b0001);
        step("timeout_b1", 4'b0001, 1, 2'd0, 16'h0001, 1'b1, 1'b0);
        drive(4'b0011, 4'b0001, 4'b0000);
        step("timeout_b2", 4'b0001, 1, 2'd0, 16'h0001, 1'b1, 1'b0);
        step("timeout_b3", 4'b0001, 1, 2'd0, 16'h0001, 1'b1, 1'b0);
        step("timeout_b4", 4'b0001, 1, 2'd0, 16'h0001, 1'b1, 1'b1);
        step("timeout_next", 4'b0010, 1, 2'd1, 16'h2224, 1'b0, 1'b1);

        // Lock abandon: requester 3 drops req while owning the adder.
        drive(4'b1000, 4'b1000, 4'b0000);
        step("abandon_b1", 4'b1000, 1, 2'd3, 16'h4448, 1'b0, 1'b0);
        drive(4'b0001, 4'b0000, 4'b0000);
        step("abandon_drop", 4'b0000, 0, 2'd0, 16'h0, 1'b0, 1'b0);
        step("abandon_arb", 4'b0001, 1, 2'd0, 16'h0000, 1'b1, 1'b1);

        // Reset mid-chain, then the first grant starts from rr_ptr=0.
        ops(2, 16'h0F0F, 16'h0101);
        drive(4'b0100, 4'b0100, 4'b0000);
        step("rst_chain_b1", 4'b0100, 1, 2'd2, 16'h1010, 1'b0, 1'b0);
        drive(4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_valid", 32'(bus.res_valid), 32'h0);
        chk("midrst_sum", 32'(bus.res_sum), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_gnt_hold", 32'(bus.gnt), 32'h0);
        chk("midrst_valid_hold", 32'(bus.res_valid), 32'h0);
        drive(4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(4'b1111, 4'b0000, 4'b0000);
        step("post_reset", 4'b0001, 1, 2'd0, 16'h0000, 1'b1, 1'b1);

        // Maximum carry on an unlocked beat.
        ops(1, 16'hFFFF, 16'hFFFF);
        drive(4'b0010, 4'b0000, 4'b0010);
        step("max_carry", 4'b0010, 1, 2'd1, 16'hFFFF, 1'b1, 1'b1);

        drive(4'b0000, 4'b0000, 4'b0000);
        step("drain1", 4'b0000, 0, 2'd0, 16'h0, 1'b0, 1'b0);
        step("drain2", 4'b0000, 0, 2'd0, 16'h0, 1'b0, 1'b0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares one 16-bit carry-select adder, instantiated internally, among NREQ requesters. Each cycle a round-robin arbiter grants one requester, and its operands go to the adder that cycle. The result is registered one cycle later and tagged with the requester ID. A lock mechanism lets one requester keep the adder for consecutive beats, with carry chained between beats, to build 32/48/64-bit adds out of 16-bit words.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must equal ceil(log2(NREQ))
MAX_LOCK, 4, maximum consecutive beats one requester may hold a lock (1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester add request
lock  input  NREQ  per-requester: keep grant for next beat and chain carry
cin  input  NREQ  per-requester carry-in, used on first/unlocked beat only
a_flat  input  16*NREQ  operand A; requester i at [16*i+15:16*i]
b_flat  input  16*NREQ  operand B, same packing
gnt  output  NREQ  one-hot combinational grant; operands consumed in this cycle
res_valid  output  1  registered result valid (one-cycle pulse per beat)
res_id  output  IDW  requester index of the result
res_sum  output  16  registered sum
res_cout  output  1  registered carry-out
res_last  output  1  1 = final beat of a chained sequence, or a single beat

Behaviour:
- Reset (rst_n=0, async): state=ARB, rr_ptr=0, carry_q=0, lock_cnt=0, res_valid=0, res_id=0, res_sum=0, res_cout=0, res_last=0. gnt=0 while rst_n=0.
- State ARB:
  - gnt = first requester with req=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - If no req, gnt=0 and no result is produced next cycle.
  - Adder cin = cin[granted].
- State LOCKED (owner = own_id):
  - gnt[own_id]=1 if req[own_id]=1; other requesters are not granted.
  - Adder cin = carry_q; cin[own_id] is ignored.
  - If req[own_id]=0: gnt=0 this cycle, go to ARB (lock released, no beat).
- Lock decision on a granted beat:
  - lock[granted]=1 and lock_cnt+1 < MAX_LOCK: next state=LOCKED, own_id=granted, lock_cnt increments.
  - Otherwise: next state=ARB, lock_cnt=0, rr_ptr=(granted+1) mod NREQ.
  - rr_ptr is frozen while LOCKED.
  - MAX_LOCK=1 means locks are never honoured.
  - A lock without req is ignored.
- On every granted beat, at the next edge:
  - res_valid=1, res_id=granted, res_sum/res_cout = adder outputs, carry_q=adder cout.
  - res_last=1 iff the beat does not transition to/stay in LOCKED.
- res_valid is low in every cycle following a cycle with gnt=0.
- Latency: operands in cycle N -> result in cycle N+1. Throughput: 1 beat/cycle, with no bubble between arbitrated grants.
- Sum is modulo 2^16, with the carry reported on res_cout. The block does not detect overflow.
- Reset asserted mid-lock: immediate return to reset values. The chain is abandoned with no res_last.

Test Plan:
- Reset, single request: req=0001, a=0x1234, b=0x0FF0, cin=0 -> gnt=0001 same cycle; next cycle res_valid=1, id=0, sum=0x2224, cout=0, last=1.
- Round-robin fairness: req=1111 held 8 cycles, lock=0 -> grant order 0,1,2,3,0,1,2,3; every result valid, ids matching order.
- Chained 32-bit add: requester 2 beat 1 a=0xFFFF, b=0x0001, cin=0, lock=1; beat 2 a=0x0000, b=0x0000, lock=0, cin=1 (ignored) -> results sum=0x0000/cout=1/last=0, then sum=0x0001/cout=0/last=1; requester 1, also requesting, receives no grant until beat 2 completes.
- Lock timeout: MAX_LOCK=4, requester 0 holds req=1, lock=1 with req=0011 -> 4 consecutive beats to id 0 (last=1 on 4th), then gnt=0010.
- Lock abandon and reset: lock held by requester 3, req[3] dropped -> gnt=0, ARB next cycle. Repeat with rst_n pulsed low mid-chain -> res_valid=0 and gnt=0 immediately; after release, first grant honours rr_ptr=0.
- Max carry: a=0xFFFF, b=0xFFFF, cin=1 unlocked -> sum=0xFFFF, cout=1.
